// File: rtl/cpu_pkg.sv
// Shared load/store definitions: data width, funct3 access encodings,
// LSU state encoding and the misalignment rule used by the MEM stage.
package cpu_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } lsu_state_e;

   // Unsigned funct3 codes only mean byte/half for loads; a store with any
   // funct3 other than SB/SH is a word store.
   function automatic logic is_misaligned(input logic [2:0] f3,
                                          input logic       is_store,
                                          input logic [1:0] addr_lo);
      logic byte_acc;
      logic half_acc;
      byte_acc = (f3 == F3_B) | (!is_store & (f3 == F3_BU));
      half_acc = (f3 == F3_H) | (!is_store & (f3 == F3_HU));
      if (byte_acc)      return 1'b0;
      else if (half_acc) return addr_lo[0];
      else               return |addr_lo;
   endfunction

endpackage

// File: rtl/lsu_load_format.sv
// Load data formatter: picks the addressed byte/halfword out of the read
// word and sign- or zero-extends it according to funct3.
module lsu_load_format
   import cpu_pkg::*;
(
   input  logic [XLEN-1:0] rdata_i,
   input  logic [1:0]      addr_lo_i,
   input  logic [2:0]      funct3_i,
   output logic [XLEN-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select and extension; unknown funct3 returns the full word.
   always_comb begin
      case (addr_lo_i)
         2'd0:    byte_sel = rdata_i[7:0];
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase
      half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (funct3_i)
         F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
         F3_BU:   data_o = {24'h0, byte_sel};
         F3_HU:   data_o = {16'h0, half_sel};
         F3_W:    data_o = rdata_i;
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one registered req/ack access per
// instruction, formats store lanes, extends load data and stalls upstream
// until the access completes.
// Optional: DMEM_TIMEOUT_EN adds a request timeout that pulses bus_err.
// Handshake: dmem_req is held high with stable addr/we/wstrb/wdata until the
// cycle in which dmem_ack=1 is seen; dmem_ack outside a request is ignored.
module mem_access_unit
   import cpu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] MEM_alu_result,
   input  logic [XLEN-1:0] MEM_rs2_data,
   input  logic [2:0]      MEM_funct3,
   input  logic            MEM_MemRead,
   input  logic            MEM_MemWrite,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [3:0]      dmem_wstrb,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic [XLEN-1:0] dmem_rdata,
   input  logic            dmem_ack,
   output logic            mem_stall,
   output logic [XLEN-1:0] lsu_rdata,
   output logic            misalign_exc,
   output logic            bus_err
);

   lsu_state_e      state_q, state_d;
   logic            req_q, req_d;
   logic            we_q, we_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [3:0]      wstrb_q, wstrb_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            misalign_q, misalign_d;

   logic            op;
   logic            misaligned;
   logic [3:0]      st_strb;
   logic [XLEN-1:0] st_wdata;
   logic [XLEN-1:0] ld_data;

`ifdef DMEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bus_err_q, bus_err_d;
`endif

   assign op         = MEM_MemRead | MEM_MemWrite;
   assign misaligned = is_misaligned(MEM_funct3, MEM_MemWrite, MEM_alu_result[1:0]);

   // Reset gates the stall so upstream sees it drop as soon as rst rises.
   assign mem_stall = op & (state_q != DONE) & ~rst;

   lsu_load_format u_load_format (
      .rdata_i   (dmem_rdata),
      .addr_lo_i (MEM_alu_result[1:0]),
      .funct3_i  (MEM_funct3),
      .data_o    (ld_data)
   );

   // Store lane strobes and lane-replicated write data.
   always_comb begin
      case (MEM_funct3)
         F3_B: begin
            st_strb  = 4'b0001 << MEM_alu_result[1:0];
            st_wdata = {4{MEM_rs2_data[7:0]}};
         end
         F3_H: begin
            st_strb  = 4'b0011 << MEM_alu_result[1:0];
            st_wdata = {2{MEM_rs2_data[15:0]}};
         end
         default: begin
            st_strb  = 4'b1111;
            st_wdata = MEM_rs2_data;
         end
      endcase
   end

   // Access FSM next-state and output-register logic.
   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wstrb_d    = wstrb_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      misalign_d = 1'b0;
`ifdef DMEM_TIMEOUT_EN
      cnt_d      = cnt_q;
      bus_err_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (op) begin
               if (misaligned) begin
                  misalign_d = 1'b1;
                  state_d    = DONE;
               end else begin
                  req_d   = 1'b1;
                  we_d    = MEM_MemWrite;
                  addr_d  = {MEM_alu_result[XLEN-1:2], 2'b00};
                  wstrb_d = MEM_MemWrite ? st_strb : 4'b0000;
                  wdata_d = MEM_MemWrite ? st_wdata : '0;
`ifdef DMEM_TIMEOUT_EN
                  cnt_d   = '0;
`endif
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (dmem_ack) begin
               req_d   = 1'b0;
               if (!we_q) rdata_d = ld_data;
               state_d = DONE;
            end
`ifdef DMEM_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               req_d     = 1'b0;
               bus_err_d = 1'b1;
               rdata_d   = '0;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset abandons any outstanding request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wstrb_q    <= 4'b0000;
         wdata_q    <= '0;
         rdata_q    <= '0;
         misalign_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
         cnt_q      <= '0;
         bus_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wstrb_q    <= wstrb_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         misalign_q <= misalign_d;
`ifdef DMEM_TIMEOUT_EN
         cnt_q      <= cnt_d;
         bus_err_q  <= bus_err_d;
`endif
      end
   end

   assign dmem_req     = req_q;
   assign dmem_we      = we_q;
   assign dmem_addr    = addr_q;
   assign dmem_wstrb   = wstrb_q;
   assign dmem_wdata   = wdata_q;
   assign lsu_rdata    = rdata_q;
   assign misalign_exc = misalign_q;
`ifdef DMEM_TIMEOUT_EN
   assign bus_err      = bus_err_q;
`else
   assign bus_err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a responsive memory model acks after
// a chosen number of request cycles; expected values are hand-computed.
// Build with +define+DMEM_TIMEOUT_EN to exercise the timeout path.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] alu_result;
   logic [31:0] rs2_data;
   logic [2:0]  funct3;
   logic        mem_read;
   logic        mem_write;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_wstrb;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        mem_stall;
   logic [31:0] lsu_rdata;
   logic        misalign_exc;
   logic        bus_err;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   // Results of the most recent access
   int          stall_cnt;
   int          exc_cnt;
   int          berr_cnt;
   int          req_cycles;
   logic        req_seen;
   logic [31:0] cap_addr;
   logic        cap_we;
   logic [3:0]  cap_wstrb;
   logic [31:0] cap_wdata;

   // Clock
   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .MEM_alu_result (alu_result),
      .MEM_rs2_data   (rs2_data),
      .MEM_funct3     (funct3),
      .MEM_MemRead    (mem_read),
      .MEM_MemWrite   (mem_write),
      .dmem_req       (dmem_req),
      .dmem_we        (dmem_we),
      .dmem_addr      (dmem_addr),
      .dmem_wstrb     (dmem_wstrb),
      .dmem_wdata     (dmem_wdata),
      .dmem_rdata     (dmem_rdata),
      .dmem_ack       (dmem_ack),
      .mem_stall      (mem_stall),
      .lsu_rdata      (lsu_rdata),
      .misalign_exc   (misalign_exc),
      .bus_err        (bus_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Presents one instruction and plays memory: ack on request cycle ack_at
   // (0 = never). Runs until stall drops or max_cyc cycles elapse.
   task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rdat, input int ack_at, input int max_cyc);
      logic done;
      stall_cnt = 0; exc_cnt = 0; berr_cnt = 0; req_cycles = 0;
      req_seen = 1'b0; done = 1'b0;
      cap_addr = '0; cap_we = 1'b0; cap_wstrb = '0; cap_wdata = '0;
      @(negedge clk);
      mem_read = rd; mem_write = wr; funct3 = f3; alu_result = addr; rs2_data = rs2;
      for (int c = 0; c < max_cyc && !done; c++) begin
         if (c != 0) @(negedge clk);
         dmem_ack = 1'b0;
         dmem_rdata = 32'h0;
         if (dmem_req) begin
            if (!req_seen) begin
               cap_addr = dmem_addr; cap_we = dmem_we;
               cap_wstrb = dmem_wstrb; cap_wdata = dmem_wdata;
            end
            req_seen = 1'b1;
            req_cycles++;
            if (req_cycles == ack_at) begin
               dmem_ack = 1'b1;
               dmem_rdata = rdat;
            end
         end
         #1;
         if (mem_stall) stall_cnt++;
         if (misalign_exc) exc_cnt++;
         if (bus_err) berr_cnt++;
         if (!mem_stall) done = 1'b1;
      end
      check("access_bound", {31'h0, done}, 32'h1);
      check("req_low_done", {31'h0, dmem_req}, 32'h0);
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0; dmem_ack = 1'b0;
      #1;
      check("pulse_end", {30'h0, misalign_exc, bus_err}, 32'h0);
   endtask

   task automatic load_test(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdat, input logic [31:0] exp);
      exp_q.push_back(exp);
      access(1'b1, 1'b0, f3, addr, 32'h0, rdat, 1, 20);
      check({tag, "_stall"}, stall_cnt, 2);
      check({tag, "_addr"}, cap_addr, {addr[31:2], 2'b00});
      check({tag, "_we_strb"}, {27'h0, cap_we, cap_wstrb}, 32'h0);
      check({tag, "_rdata"}, lsu_rdata, exp_q.pop_front());
   endtask

   task automatic store_test(input string tag, input logic rd, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] rs2, input int ack_at,
                             input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                             input int exp_stall, input logic [31:0] prev_rdata);
      access(rd, 1'b1, f3, addr, rs2, 32'hFFFF_FFFF, ack_at, 20);
      check({tag, "_addr"}, cap_addr, {addr[31:2], 2'b00});
      check({tag, "_we"}, {31'h0, cap_we}, 32'h1);
      check({tag, "_wstrb"}, {28'h0, cap_wstrb}, {28'h0, exp_strb});
      check({tag, "_wdata"}, cap_wdata, exp_wdata);
      check({tag, "_stall"}, stall_cnt, exp_stall);
      check({tag, "_rdata_kept"}, lsu_rdata, prev_rdata);
   endtask

   task automatic misalign_test(input string tag, input logic rd, input logic wr,
                                input logic [2:0] f3, input logic [31:0] addr);
      access(rd, wr, f3, addr, 32'h5555_AAAA, 32'h0, 1, 20);
      check({tag, "_exc"}, exc_cnt, 1);
      check({tag, "_noreq"}, {31'h0, req_seen}, 32'h0);
      check({tag, "_stall"}, stall_cnt, 1);
   endtask

   initial begin
      // Reset
      rst = 1'b1;
      alu_result = '0; rs2_data = '0; funct3 = '0; mem_read = 1'b0; mem_write = 1'b0;
      dmem_rdata = '0; dmem_ack = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_outputs", {dmem_req, dmem_we, mem_stall, misalign_exc, bus_err, dmem_wstrb},
            32'h0);
      check("rst_addr_wdata", dmem_addr | dmem_wdata, 32'h0);
      check("rst_rdata", lsu_rdata, 32'h0);
      rst = 1'b0;

      // Ack with no request outstanding is ignored
      @(negedge clk);
      dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      dmem_ack = 1'b0;
      check("stray_ack_req", {31'h0, dmem_req}, 32'h0);
      check("stray_ack_rdata", lsu_rdata, 32'h0);

      // Loads
      load_test("lb",  3'b000, 32'h0000_0202, 32'h1180_2233, 32'hFFFF_FF80);
      load_test("lbu", 3'b100, 32'h0000_0202, 32'h1180_2233, 32'h0000_0080);
      load_test("lhu", 3'b101, 32'h0000_0202, 32'h1180_2233, 32'h0000_1180);
      load_test("lb1", 3'b000, 32'h0000_0201, 32'h1180_2233, 32'h0000_0022);
      load_test("lh0", 3'b001, 32'h0000_0200, 32'h1180_2233, 32'h0000_2233);
      load_test("lh2", 3'b001, 32'h0000_0202, 32'h8001_0000, 32'hFFFF_8001);
      load_test("lw11", 3'b011, 32'h0000_0308, 32'h1357_2468, 32'h1357_2468);
      load_test("lw",  3'b010, 32'h0000_0304, 32'hCAFE_F00D, 32'hCAFE_F00D);

      // Stores (lsu_rdata must keep the last load result)
      store_test("sw", 1'b0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 2,
                 4'b1111, 32'hDEAD_BEEF, 3, 32'hCAFE_F00D);
      store_test("sb", 1'b0, 3'b000, 32'h0000_0103, 32'h0000_00A5, 1,
                 4'b1000, 32'hA5A5_A5A5, 2, 32'hCAFE_F00D);
      store_test("sh", 1'b0, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 3,
                 4'b1100, 32'hBEEF_BEEF, 4, 32'hCAFE_F00D);
      store_test("rdwr", 1'b1, 3'b000, 32'h0000_0101, 32'h0000_003C, 1,
                 4'b0010, 32'h3C3C_3C3C, 2, 32'hCAFE_F00D);

      // Misaligned accesses
      misalign_test("mis_lw", 1'b1, 1'b0, 3'b010, 32'h0000_0302);
      misalign_test("mis_lh", 1'b1, 1'b0, 3'b001, 32'h0000_0301);
      misalign_test("mis_sh", 1'b0, 1'b1, 3'b001, 32'h0000_0103);

      // Reset while a request is outstanding
      @(negedge clk);
      mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; alu_result = 32'h0000_0400;
      @(negedge clk);
      check("mid_rst_pre_req", {31'h0, dmem_req}, 32'h1);
      rst = 1'b1;
      #1;
      check("mid_rst_req", {31'h0, dmem_req}, 32'h0);
      check("mid_rst_stall", {31'h0, mem_stall}, 32'h0);
      check("mid_rst_rdata", lsu_rdata, 32'h0);
      mem_read = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      load_test("post_rst_lw", 3'b010, 32'h0000_0400, 32'h1234_5678, 32'h1234_5678);

`ifdef DMEM_TIMEOUT_EN
      // No ack: timeout after 4 request cycles
      access(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h0BAD_F00D, 0, 20);
      check("to_req_cycles", req_cycles, 4);
      check("to_bus_err", berr_cnt, 1);
      check("to_rdata", lsu_rdata, 32'h0);
      check("to_stall", stall_cnt, 5);
      // Ack on the 4th request cycle beats the timeout
      access(1'b1, 1'b0, 3'b010, 32'h0000_0504, 32'h0, 32'h600D_CAFE, 4, 20);
      check("ack4_req_cycles", req_cycles, 4);
      check("ack4_bus_err", berr_cnt, 0);
      check("ack4_rdata", lsu_rdata, 32'h600D_CAFE);
`else
      // Without the timeout the request waits as long as memory takes
      access(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h600D_CAFE, 30, 40);
      check("slow_req_cycles", req_cycles, 30);
      check("slow_bus_err", berr_cnt, 0);
      check("slow_rdata", lsu_rdata, 32'h600D_CAFE);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
